latch_ctrl: RTL and testbench
=============================

LATCH_CTRL -- requirements
Module: latch_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data width of each latch slot and of every data port.
REQ-002 Parameter: NSLOT, 4, number of latch slots driven (fixed at 4; addresses are 2 bits).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 Port: a_valid/b_valid  input  1  requester A/B has a command pending.
REQ-006 Port: a_ready/b_ready  output  1  command from A/B is accepted this cycle (transfer = valid && ready).
REQ-007 Port: a_op/b_op  input  2  00 WRITE, 01 CLEAR, 10 PRESET, 11 READ.
REQ-008 Port: a_addr/b_addr  input  2  target slot index 0..3.
REQ-009 Port: a_data/b_data  input  WIDTH  write data, used by WRITE only.
REQ-010 Port: lat_d  output  WIDTH  data bus to the latch bank.
REQ-011 Port: lat_ena / lat_clr / lat_pre  output  4 each  per-slot enable, clear and preset strobes, active-high.
REQ-012 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-013 Port: rd_valid  output  1; rd_data  output  WIDTH; rd_id  output  1 (0=A, 1=B)  readback response.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, STROBE, HOLD; transitions IDLE->SETUP on a transfer, SETUP->STROBE, STROBE->HOLD, HOLD->IDLE unconditionally.
REQ-015 Ready SHALL be asserted only in IDLE, to at most one requester, and only when that requester's valid is high.
REQ-016 Only one requester valid -> it is granted; both valid -> the requester indicated by the round-robin pointer is granted.
REQ-017 The pointer SHALL point to the requester not served after every transfer; after reset it points to A.
REQ-018 On transfer the op, addr, data and requester id SHALL be registered; inputs are ignored until the next IDLE.
REQ-019 SETUP: lat_d = captured value (WRITE: data; CLEAR: all zeros; PRESET: all ones; READ: lat_d unchanged); all strobes 0.
REQ-020 STROBE: exactly one bit, bit[addr], of lat_ena (WRITE), lat_clr (CLEAR) or lat_pre (PRESET) is high; READ drives no strobe.
REQ-021 HOLD: all strobes 0, lat_d held at the SETUP value.
REQ-022 lat_clr and lat_pre SHALL never be high in the same cycle; at most one strobe bit is high in any cycle.
REQ-023 Throughput: one command per 4 cycles; a command accepted in cycle N strobes in N+2 and the next accept can occur in N+4.
REQ-024 busy SHALL be high in SETUP, STROBE and HOLD and low in IDLE.

Reset
REQ-025 While rst is high at a clock edge: state=IDLE, pointer=A, lat_d=0, all strobes=0, busy=0, a_ready=b_ready=0, rd_valid=0, rd_data=0, rd_id=0, shadow=0.
REQ-026 Reset asserted mid-command SHALL abandon the command on that edge; no strobe or rd_valid is produced for it.

Configuration
REQ-027 Macro LATCH_CTRL_SHADOW_EN defined: a WIDTH x 4 shadow array is updated at the end of STROBE (WRITE->data, CLEAR->0, PRESET->all ones).
REQ-028 With LATCH_CTRL_SHADOW_EN: READ pulses rd_valid for one cycle in STROBE with rd_data = shadow[addr] and rd_id = requester.
REQ-029 Without LATCH_CTRL_SHADOW_EN: no shadow storage; READ runs the full 4-state sequence with no strobes; rd_valid, rd_data, rd_id are constant 0.

Verification
REQ-030 A WRITE addr=2 data=8'hA5, B idle -> a_ready in cycle 0, lat_d=A5 in cycles 1-3, lat_ena=4'b0100 only in cycle 2, busy cycles 1-3.
REQ-031 A and B both valid continuously after reset -> grants alternate A,B,A,B at cycles 0,4,8,12.
REQ-032 B CLEAR addr=1 then B PRESET addr=1 -> lat_clr=4'b0010 with lat_d=00, then lat_pre=4'b0010 with lat_d=FF; never both strobes together.
REQ-033 (SHADOW_EN) WRITE addr=3 data=3C, then READ addr=3 from B -> rd_valid one cycle, rd_data=3C, rd_id=1; without the macro rd_valid stays 0.
REQ-034 rst asserted in the SETUP cycle of a WRITE addr=0 -> no lat_ena pulse, all outputs 0 next cycle, first grant afterwards goes to A.

Source files
------------

// File: rtl/latch_ctrl.sv
// latch_ctrl: round-robin arbiter for two requesters that sequences WRITE/CLEAR/PRESET/READ onto a
// 4-slot latch bank (IDLE->SETUP->STROBE->HOLD). Define LATCH_CTRL_SHADOW_EN for shadow storage + READ data.
module latch_ctrl #(
   parameter int WIDTH = 8,
   parameter int NSLOT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [1:0]       a_op,
   input  logic [1:0]       a_addr,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [1:0]       b_op,
   input  logic [1:0]       b_addr,
   input  logic [WIDTH-1:0] b_data,
   output logic [WIDTH-1:0] lat_d,
   output logic [NSLOT-1:0] lat_ena,
   output logic [NSLOT-1:0] lat_clr,
   output logic [NSLOT-1:0] lat_pre,
   output logic             busy,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_id
);
   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_CLEAR  = 2'b01;
   localparam logic [1:0] OP_PRESET = 2'b10;
   localparam logic [1:0] OP_READ   = 2'b11;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [1:0] addr;
   } cmd_t;

   state_t           state, state_nxt;
   cmd_t             cmd_q, req_cmd;
   logic [WIDTH-1:0] req_data;
   logic             ptr_q;
   logic             grant_b;
   logic             xfer;
   logic             in_strobe;

   // Ready is gated by rst so nothing is accepted on an edge that resets the block.
   always_comb begin
      grant_b      = b_valid;
      if (a_valid && b_valid)
         grant_b   = ptr_q;
      xfer         = (state == IDLE) && !rst && (a_valid || b_valid);
      a_ready      = xfer && !grant_b;
      b_ready      = xfer && grant_b;
      req_cmd.op   = grant_b ? b_op   : a_op;
      req_cmd.addr = grant_b ? b_addr : a_addr;
      req_data     = grant_b ? b_data : a_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = SETUP;
         SETUP:   state_nxt = STROBE;
         STROBE:  state_nxt = HOLD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr_q <= 1'b0;
         cmd_q <= '0;
         lat_d <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            ptr_q <= ~grant_b;
            cmd_q <= req_cmd;
            // lat_d is loaded on the accept edge so it is stable from SETUP through HOLD.
            case (req_cmd.op)
               OP_WRITE:  lat_d <= req_data;
               OP_CLEAR:  lat_d <= '0;
               OP_PRESET: lat_d <= '1;
               default:   lat_d <= lat_d;
            endcase
         end
      end
   end

   assign busy      = (state != IDLE);
   assign in_strobe = (state == STROBE);

`ifdef LATCH_CTRL_SHADOW_EN
   logic [NSLOT-1:0][WIDTH-1:0] shadow;
   logic                        id_q;
`endif

   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      logic hit;
      assign hit        = in_strobe && (cmd_q.addr == 2'(i));
      assign lat_ena[i] = hit && (cmd_q.op == OP_WRITE);
      assign lat_clr[i] = hit && (cmd_q.op == OP_CLEAR);
      assign lat_pre[i] = hit && (cmd_q.op == OP_PRESET);
`ifdef LATCH_CTRL_SHADOW_EN
      // lat_d already carries the value the slot takes (data, zeros or ones).
      logic [WIDTH-1:0] shadow_q;
      always_ff @(posedge clk) begin
         if (rst)
            shadow_q <= '0;
         else if (hit && (cmd_q.op != OP_READ))
            shadow_q <= lat_d;
      end
      assign shadow[i] = shadow_q;
`endif
   end

`ifdef LATCH_CTRL_SHADOW_EN
   always_ff @(posedge clk) begin
      if (rst)
         id_q <= 1'b0;
      else if (xfer)
         id_q <= grant_b;
   end

   assign rd_valid = in_strobe && (cmd_q.op == OP_READ);
   assign rd_data  = rd_valid ? shadow[cmd_q.addr] : '0;
   assign rd_id    = rd_valid && id_q;
`else
   assign rd_valid = 1'b0;
   assign rd_data  = '0;
   assign rd_id    = 1'b0;
`endif

   a_one_stb: assert property (@(posedge clk) disable iff (rst)
      $onehot0({lat_ena, lat_clr, lat_pre}));
   a_one_rdy: assert property (@(posedge clk) disable iff (rst)
      !(a_ready && b_ready));
   a_rdy_idle: assert property (@(posedge clk) disable iff (rst)
      (a_ready || b_ready) |-> (state == IDLE));

endmodule

// File: tb/tb_latch_ctrl.sv
// Directed bench for latch_ctrl: per-command cycle checks, arbitration, reset abandon, strobe exclusivity.
module tb_latch_ctrl;
   localparam int WIDTH = 8;
`ifdef LATCH_CTRL_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             a_valid, b_valid;
   logic             a_ready, b_ready;
   logic [1:0]       a_op, b_op, a_addr, b_addr;
   logic [WIDTH-1:0] a_data, b_data;
   logic [WIDTH-1:0] lat_d;
   logic [3:0]       lat_ena, lat_clr, lat_pre;
   logic             busy, rd_valid, rd_id;
   logic [WIDTH-1:0] rd_data;
   logic             mon_en = 1'b0;

   int n_tot = 0;
   int n_bad = 0;

   latch_ctrl #(.WIDTH(WIDTH), .NSLOT(4)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_addr(b_addr), .b_data(b_data),
      .lat_d(lat_d), .lat_ena(lat_ena), .lat_clr(lat_clr), .lat_pre(lat_pre),
      .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic ar, input logic br, input logic [7:0] d,
                      input logic [3:0] ena, input logic [3:0] clr, input logic [3:0] pre,
                      input logic bsy);
      #1;
      chk({tag, ".a_ready"}, a_ready, ar);
      chk({tag, ".b_ready"}, b_ready, br);
      chk({tag, ".lat_d"},   lat_d,   d);
      chk({tag, ".lat_ena"}, lat_ena, ena);
      chk({tag, ".lat_clr"}, lat_clr, clr);
      chk({tag, ".lat_pre"}, lat_pre, pre);
      chk({tag, ".busy"},    busy,    bsy);
   endtask

   task automatic rdchk(input string tag, input logic rv, input logic [7:0] rd, input logic id);
      chk({tag, ".rd_valid"}, rd_valid, rv);
      chk({tag, ".rd_data"},  rd_data,  rd);
      chk({tag, ".rd_id"},    rd_id,    id);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1;
      nxt();
      nxt();
      cyc("rst", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
      rdchk("rst", 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   // One full command: accept cycle then SETUP/STROBE/HOLD, all expectations supplied by caller.
   task automatic cmd4(input string tag, input logic is_b, input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] data, input logic [7:0] d_prev, input logic [7:0] d_new,
                       input logic [3:0] ena, input logic [3:0] clr, input logic [3:0] pre,
                       input logic rv, input logic [7:0] rd);
      nxt();
      if (is_b) begin
         b_valid = 1'b1; b_op = op; b_addr = addr; b_data = data; a_valid = 1'b0;
      end else begin
         a_valid = 1'b1; a_op = op; a_addr = addr; a_data = data; b_valid = 1'b0;
      end
      cyc({tag, ".c0"}, !is_b, is_b, d_prev, 4'h0, 4'h0, 4'h0, 1'b0);
      rdchk({tag, ".c0"}, 1'b0, 8'h00, 1'b0);
      nxt();
      a_valid = 1'b0; b_valid = 1'b0;
      cyc({tag, ".c1"}, 1'b0, 1'b0, d_new, 4'h0, 4'h0, 4'h0, 1'b1);
      rdchk({tag, ".c1"}, 1'b0, 8'h00, 1'b0);
      nxt();
      cyc({tag, ".c2"}, 1'b0, 1'b0, d_new, ena, clr, pre, 1'b1);
      rdchk({tag, ".c2"}, rv, rd, rv && is_b);
      nxt();
      cyc({tag, ".c3"}, 1'b0, 1'b0, d_new, 4'h0, 4'h0, 4'h0, 1'b1);
      rdchk({tag, ".c3"}, 1'b0, 8'h00, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon.one_strobe", ($countones({lat_ena, lat_clr, lat_pre}) <= 1), 1);
         chk("mon.clr_pre",    |(lat_clr & lat_pre), 0);
      end
   end

   initial begin
      a_op = 2'b00; a_addr = 2'b00; a_data = 8'h00;
      b_op = 2'b00; b_addr = 2'b00; b_data = 8'h00;
      do_reset();
      mon_en = 1'b1;

      //    tag     B     op     addr   data   d_prev d_new  ena      clr      pre      rv         rd
      cmd4("wr2",  1'b0, 2'b00, 2'd2, 8'hA5, 8'h00, 8'hA5, 4'b0100, 4'b0000, 4'b0000, 1'b0, 8'h00);
      cmd4("clr1", 1'b1, 2'b01, 2'd1, 8'h5A, 8'hA5, 8'h00, 4'b0000, 4'b0010, 4'b0000, 1'b0, 8'h00);
      cmd4("pre1", 1'b1, 2'b10, 2'd1, 8'h5A, 8'h00, 8'hFF, 4'b0000, 4'b0000, 4'b0010, 1'b0, 8'h00);
      cmd4("wr3",  1'b0, 2'b00, 2'd3, 8'h3C, 8'hFF, 8'h3C, 4'b1000, 4'b0000, 4'b0000, 1'b0, 8'h00);
      cmd4("rd3",  1'b1, 2'b11, 2'd3, 8'h99, 8'h3C, 8'h3C, 4'b0000, 4'b0000, 4'b0000, SH, SH ? 8'h3C : 8'h00);
      cmd4("rd2",  1'b0, 2'b11, 2'd2, 8'h99, 8'h3C, 8'h3C, 4'b0000, 4'b0000, 4'b0000, SH, SH ? 8'hA5 : 8'h00);
      cmd4("rd1",  1'b1, 2'b11, 2'd1, 8'h99, 8'h3C, 8'h3C, 4'b0000, 4'b0000, 4'b0000, SH, SH ? 8'hFF : 8'h00);

      // Both requesters hold valid: grants alternate A,B,A,B every 4 cycles starting at A.
      do_reset();
      nxt();
      a_valid = 1'b1; a_op = 2'b00; a_addr = 2'd0; a_data = 8'h11;
      b_valid = 1'b1; b_op = 2'b00; b_addr = 2'd1; b_data = 8'h22;
      for (int c = 0; c < 16; c++) begin
         #1;
         chk($sformatf("rr%0d.a_ready", c), a_ready, (c % 8) == 0);
         chk($sformatf("rr%0d.b_ready", c), b_ready, (c % 8) == 4);
         chk($sformatf("rr%0d.busy", c), busy, (c % 4) != 0);
         chk($sformatf("rr%0d.lat_ena", c), lat_ena,
             ((c % 8) == 2) ? 4'b0001 : (((c % 8) == 6) ? 4'b0010 : 4'b0000));
         if (c > 0)
            chk($sformatf("rr%0d.lat_d", c), lat_d,
                ((c % 8) >= 1 && (c % 8) <= 4) ? 8'h11 : 8'h22);
         nxt();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) nxt();

      // Reset during SETUP of an A WRITE abandons it; A wins the next tie.
      do_reset();
      nxt();
      a_valid = 1'b1; a_op = 2'b00; a_addr = 2'd0; a_data = 8'h77; b_valid = 1'b0;
      cyc("rs.c0", 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
      nxt();
      a_valid = 1'b0; rst = 1'b1;
      cyc("rs.c1", 1'b0, 1'b0, 8'h77, 4'h0, 4'h0, 4'h0, 1'b1);
      nxt();
      rst = 1'b0;
      cyc("rs.c2", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
      rdchk("rs.c2", 1'b0, 8'h00, 1'b0);
      nxt();
      cyc("rs.c3", 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
      nxt();
      a_valid = 1'b1; b_valid = 1'b1; b_op = 2'b01; b_addr = 2'd2;
      cyc("rs.c4", 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
      nxt();
      a_valid = 1'b0; b_valid = 1'b0;
      cyc("rs.c5", 1'b0, 1'b0, 8'h77, 4'h0, 4'h0, 4'h0, 1'b1);
      nxt();
      cyc("rs.c6", 1'b0, 1'b0, 8'h77, 4'b0001, 4'h0, 4'h0, 1'b1);
      repeat (3) nxt();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
